// File: rtl/alu8_if.sv
// Operand/opcode bus into the ALU and registered result/flags bus out of it.
// The master drives the operands and the opcode; the slave (the ALU) drives the result and flags.
interface alu8_if;
  logic [7:0] A;
  logic [7:0] B;
  logic [2:0] ALUOp;
  logic [7:0] Result;
  logic       Zero;
  logic       Carry;
  logic       Negative;
  logic       Overflow;

  modport master (
    output A, B, ALUOp,
    input  Result, Zero, Carry, Negative, Overflow
  );

  modport slave (
    input  A, B, ALUOp,
    output Result, Zero, Carry, Negative, Overflow
  );
endinterface

// File: rtl/alu8.sv
// 8-bit ALU: eight ops with registered result and Z/C/N/V flags, 1-clock latency.
// No backpressure: a new op is accepted every cycle; async reset clears outputs immediately.
module alu8 (
  input  logic   clk,
  input  logic   rst_n,
  alu8_if.slave  bus
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_e;

  logic [8:0] w_sum;
  logic [8:0] w_diff;
  logic [7:0] w_res;
  logic       w_carry;
  logic       w_ovf;

  logic [7:0] r_result;
  logic       r_zero;
  logic       r_carry;
  logic       r_neg;
  logic       r_ovf;

  // Bit 8 of the 9-bit difference is the unsigned borrow (A < B).
  assign w_sum  = {1'b0, bus.A} + {1'b0, bus.B};
  assign w_diff = {1'b0, bus.A} - {1'b0, bus.B};

  always_comb begin
    w_res   = 8'h00;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (op_e'(bus.ALUOp))
      OP_ADD: begin
        w_res   = w_sum[7:0];
        w_carry = w_sum[8];
        w_ovf   = (bus.A[7] == bus.B[7]) && (w_sum[7] != bus.A[7]);
      end
      OP_SUB: begin
        w_res   = w_diff[7:0];
        w_carry = w_diff[8];
        w_ovf   = (bus.A[7] != bus.B[7]) && (w_diff[7] != bus.A[7]);
      end
      OP_AND: w_res = bus.A & bus.B;
      OP_OR:  w_res = bus.A | bus.B;
      OP_XOR: w_res = bus.A ^ bus.B;
      OP_NOT: w_res = ~bus.A;
      OP_SHL: begin
        w_res   = {bus.A[6:0], 1'b0};
        w_carry = bus.A[7];
      end
      OP_SHR: begin
        w_res   = {1'b0, bus.A[7:1]};
        w_carry = bus.A[0];
      end
      default: w_res = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= 8'h00;
      r_zero   <= 1'b1;
      r_carry  <= 1'b0;
      r_neg    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_result <= w_res;
      r_zero   <= (w_res == 8'h00);
      r_carry  <= w_carry;
      r_neg    <= w_res[7];
      r_ovf    <= w_ovf;
    end
  end

  assign bus.Result   = r_result;
  assign bus.Zero     = r_zero;
  assign bus.Carry    = r_carry;
  assign bus.Negative = r_neg;
  assign bus.Overflow = r_ovf;

endmodule

// File: tb/tb_alu8.sv
// Self-checking bench for alu8: directed vectors, random back-to-back ops,
// input-hold between edges and asynchronous mid-cycle reset.
module tb_alu8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  alu8_if bus ();

  alu8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Expected {Result, Zero, Carry, Negative, Overflow} from plain integer arithmetic.
  function automatic logic [11:0] model(input int a, input int b, input int op);
    int r, sa, sb, s;
    bit c, v;
    c  = 0;
    v  = 0;
    r  = 0;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    case (op)
      0: begin r = (a + b) % 256; c = (a + b) > 255; s = sa + sb; v = (s > 127) || (s < -128); end
      1: begin r = (a - b + 256) % 256; c = a < b; s = sa - sb; v = (s > 127) || (s < -128); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 255 - a;
      6: begin r = (a * 2) % 256; c = a >= 128; end
      default: begin r = a / 2; c = (a % 2) == 1; end
    endcase
    return {8'(r), (r == 0), c, (r >= 128), v};
  endfunction

  logic [11:0] last_exp;

  task automatic run_vec(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input string tag);
    @(negedge clk);
    bus.A     = a;
    bus.B     = b;
    bus.ALUOp = op;
    last_exp  = model(int'(a), int'(b), int'(op));
    @(posedge clk);
    #1;
    chk({tag, "_res"}, {24'h0, bus.Result}, {24'h0, last_exp[11:4]});
    chk({tag, "_zcnv"}, {28'h0, bus.Zero, bus.Carry, bus.Negative, bus.Overflow}, {28'h0, last_exp[3:0]});
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
  } vec_t;

  vec_t dir[14];

  initial begin
    bus.A = 8'h00;
    bus.B = 8'h00;
    bus.ALUOp = 3'b000;

    // Reset held: clock and inputs toggle, outputs must stay at reset values.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.A = 8'($urandom);
      bus.B = 8'($urandom);
      bus.ALUOp = 3'($urandom);
      @(posedge clk);
      #1;
      chk("rst_res", {24'h0, bus.Result}, 32'h0);
      chk("rst_zcnv", {28'h0, bus.Zero, bus.Carry, bus.Negative, bus.Overflow}, 32'h8);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int op = 0; op < 8; op++) dir[op] = '{8'h0A, 8'h05, 3'(op)};
    dir[8]  = '{8'h7F, 8'h01, 3'd0};
    dir[9]  = '{8'hFF, 8'h01, 3'd0};
    dir[10] = '{8'h05, 8'h0A, 3'd1};
    dir[11] = '{8'h80, 8'h01, 3'd1};
    dir[12] = '{8'h81, 8'h00, 3'd6};
    dir[13] = '{8'h81, 8'h00, 3'd7};
    for (int i = 0; i < 14; i++) run_vec(dir[i].a, dir[i].b, dir[i].op, $sformatf("dir%0d", i));

    // Spot constants for the documented wrap-around cases.
    run_vec(8'hFF, 8'h01, 3'd0, "wrap_add");
    chk("wrap_add_const", {24'h0, bus.Result, bus.Carry, bus.Zero, 6'h0}, {24'h0, 8'h00, 1'b1, 1'b1, 6'h0});
    run_vec(8'h00, 8'h01, 3'd1, "wrap_sub");
    chk("wrap_sub_const", {24'h0, bus.Result, bus.Carry, bus.Negative, 6'h0}, {24'h0, 8'hFF, 1'b1, 1'b1, 6'h0});

    for (int i = 0; i < 300; i++)
      run_vec(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), "rnd");

    // Inputs changing between edges must not disturb the held outputs.
    run_vec(8'h3C, 8'h11, 3'd0, "hold_pre");
    bus.A = 8'hFF;
    bus.B = 8'hFF;
    bus.ALUOp = 3'd5;
    #2;
    chk("hold_res", {24'h0, bus.Result}, {24'h0, last_exp[11:4]});
    chk("hold_zcnv", {28'h0, bus.Zero, bus.Carry, bus.Negative, bus.Overflow}, {28'h0, last_exp[3:0]});

    // Asynchronous reset between edges clears outputs without a clock edge.
    run_vec(8'h7F, 8'h01, 3'd0, "areset_pre");
    #1;
    rst_n = 1'b0;
    #1;
    chk("areset_res", {24'h0, bus.Result}, 32'h0);
    chk("areset_zcnv", {28'h0, bus.Zero, bus.Carry, bus.Negative, bus.Overflow}, 32'h8);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(8'h81, 8'h00, 3'd7, "post_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/alu8.md
# alu8

8-bit arithmetic/logic unit for the 8-bit CPU datapath. It takes two 8-bit operands and a 3-bit opcode from the decode/register-file stage. It performs one of eight operations and delivers a registered result plus status flags to the writeback and branch logic one clock later. Each cycle is independent: no internal state beyond the output registers.

## Interface
- No parameters; data width fixed at 8 bits, opcode width fixed at 3 bits.
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- A  input  8  operand A (unsigned/two's-complement, op-dependent).
- B  input  8  operand B; ignored for NOT/SHL/SHR.
- ALUOp  input  3  operation select.
- Result  output  8  registered operation result.
- Zero  output  1  registered; 1 when Result == 8'h00.
- Carry  output  1  registered carry/borrow/shift-out flag.
- Negative  output  1  registered; equals Result[7].
- Overflow  output  1  registered signed-overflow flag.

## Operation
- Opcode map (ALUOp → Result):
  - 000 ADD: (A + B) mod 256.
  - 001 SUB: (A − B) mod 256.
  - 010 AND: A & B.
  - 011 OR: A | B.
  - 100 XOR: A ^ B.
  - 101 NOT: ~A.
  - 110 SHL: {A[6:0],0}, logical.
  - 111 SHR: {0,A[7:1]}, logical.
- Carry:
  - ADD: bit 8 of the 9-bit sum.
  - SUB: borrow, 1 iff A < B unsigned.
  - SHL: A[7].
  - SHR: A[0].
  - AND/OR/XOR/NOT: 0.
- Overflow:
  - ADD: A[7]==B[7] && Result[7]!=A[7].
  - SUB: A[7]!=B[7] && Result[7]!=A[7].
  - All other ops: 0.
- Zero and Negative are derived from the 8-bit result of the same operation, for every opcode.
- All eight opcodes are defined; no illegal-opcode handling.
- The next-state result/flags logic is purely combinational from A, B, ALUOp; no dependence on prior results (no carry-in chaining).

## Timing
- Latency: 1 clock. Inputs sampled on rising edge N; Result and all flags valid after edge N and held until edge N+1.
- Throughput: one operation per clock; a new opcode/operands may be presented every cycle.
- Reset values while rst_n=0, asserted asynchronously without waiting for clk:
  - Result=8'h00, Zero=1, Carry=0, Negative=0, Overflow=0.
- Reset mid-operation: an in-flight result is discarded; outputs take reset values immediately.
- First valid result appears after the first rising edge following rst_n deassertion.
- Inputs changing between edges have no effect on outputs until the next rising edge.
- Wrap-around:
  - ADD FF+01 → 00, Carry=1, Zero=1.
  - SUB 00−01 → FF, Carry=1, Negative=1.

## Test plan
- Reset: hold rst_n=0, toggle clk and inputs → Result=00, Zero=1, other flags 0. Then release rst_n.
- Basic ops, A=0A, B=05, each opcode held for one cycle → Result and Zero as follows:
  - ADD 0F, Zero=0.
  - SUB 05, Zero=0.
  - AND 00, Zero=1.
  - OR 0F, Zero=0.
  - XOR 0F, Zero=0.
  - NOT F5, Zero=0, Negative=1.
  - SHL 14, Zero=0.
  - SHR 05, Zero=0.
- Arithmetic flags:
  - ADD 7F+01 → 80, Overflow=1, Negative=1, Carry=0.
  - ADD FF+01 → 00, Carry=1, Zero=1.
  - SUB 05−0A → FB, Carry=1.
  - SUB 80−01 → 7F, Overflow=1.
- Shift-out: SHL A=81 → 02, Carry=1. SHR A=81 → 40, Carry=1.
- Latency/back-to-back: change ALUOp every cycle → each Result appears exactly one edge after its inputs. Assert rst_n low between edges → outputs reset immediately.
